// File: rtl/cache_pkg.sv
// Shared types and helpers for the CPU-side 2-way write-back cache.
package cache_pkg;

    localparam int TAG_W     = 10;
    localparam int IDX_W     = 5;
    localparam int OFF_W     = 4;
    localparam int WAYS      = 2;
    localparam int SETS      = 1 << IDX_W;
    localparam int HIT_LAT   = 2;
    localparam int MEM_LAT   = 8;
    localparam int LINE_W    = 128;
    localparam int LADDR_W   = TAG_W + IDX_W;
    localparam int MEM_LINES = 1 << LADDR_W;

    typedef enum logic [2:0] {
        C_NOP, C_READ8, C_READ16, C_READ32,
        C_INVAL, C_WRITE8, C_WRITE16, C_WRITE32
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [18:0] a);
        return a[18:9];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [18:0] a);
        return a[8:4];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [18:0] a);
        return a[3:0];
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd1:    return 32'h0000_00ff;
            2'd2:    return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    // Bit shift of the access inside the line; low offset bits dropped by size.
    function automatic logic [6:0] byte_shift(input logic [1:0] sz,
                                              input logic [3:0] off);
        logic [3:0] al;
        case (sz)
            2'd2:    al = off & 4'b1110;
            2'd3:    al = off & 4'b1100;
            default: al = off;
        endcase
        return {al, 3'b000};
    endfunction

endpackage

// File: rtl/cache_mem_model.sv
// Line-granular 512 KiB backing store with a fixed transfer latency.
module cache_mem_model
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               we,
    input  logic [LADDR_W-1:0] line_addr,
    input  logic [LINE_W-1:0]  wdata,
    output logic [LINE_W-1:0]  rdata,
    output logic               done
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 2);

    bit   [LINE_W-1:0]  mem_q [MEM_LINES];
    logic               busy_q, busy_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [LADDR_W-1:0] laddr_q, laddr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;

    assign done  = busy_q && (cnt_q == 4'd0);
    assign rdata = mem_q[laddr_q];

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        laddr_d = laddr_q;
        wdata_d = wdata_q;
        if (busy_q) begin
            if (cnt_q == 4'd0) busy_d = 1'b0;
            else               cnt_d  = cnt_q - 4'd1;
        end else if (req) begin
            busy_d  = 1'b1;
            cnt_d   = CNT_LOAD;
            we_d    = we;
            laddr_d = line_addr;
            wdata_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            laddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            laddr_q <= laddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Commit only on the final cycle so an aborted write-back leaves memory intact.
    always_ff @(posedge clk) begin
        if (done && we_q) mem_q[laddr_q] <= wdata_q;
    end

endmodule

// File: rtl/cache_cpu.sv
// CPU-facing 2-way set-associative write-back, write-allocate cache.
module cache_cpu
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [2:0]  comm,
    input  logic [19:0] addr,
    input  logic [31:0] dat,
    output logic        ready,
    output logic        done,
    output logic [31:0] result
);

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic [18:0]        addr_q, addr_d;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        result_q, result_d;
    logic               done_q, done_d;
    logic               way_q, way_d;
    line_t              lines_q [SETS][WAYS];
    logic [SETS-1:0]    lru_q;

    logic               line_we, line_way, lru_we, lru_val;
    line_t              line_wdata;
    logic               mem_req, mem_we, mem_done;
    logic [LADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata, mem_rdata;
    logic               unused_addr;

    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   off;
    logic [1:0]         sz;
    logic               is_inv, is_wr, accept;
    logic               hit0, hit1, hit, vway;
    line_t              l0, l1, hline, vline, wline;
    logic [6:0]         sh;
    logic [31:0]        msk, rd_word;
    logic [LINE_W-1:0]  wr_data;

    assign unused_addr = addr[19];
    assign tag    = addr_tag(addr_q);
    assign idx    = addr_idx(addr_q);
    assign off    = addr_off(addr_q);
    assign sz     = cmd_q[1:0];
    assign is_inv = (cmd_q == C_INVAL);
    assign is_wr  = cmd_q[2];
    assign ready  = (state_q == S_IDLE) && !done_q;
    assign accept = ready && valid && (comm != 3'd0);
    assign done   = done_q;
    assign result = result_q;

    assign l0    = lines_q[idx][0];
    assign l1    = lines_q[idx][1];
    assign hit0  = l0.valid && (l0.tag == tag);
    assign hit1  = l1.valid && (l1.tag == tag);
    assign hit   = hit0 || hit1;
    assign hline = hit1 ? l1 : l0;
    // lru_q holds the index of the least recently used way.
    assign vway  = !l0.valid ? 1'b0 : !l1.valid ? 1'b1 : lru_q[idx];
    assign vline = vway ? l1 : l0;
    assign wline = way_q ? l1 : l0;

    assign sh      = byte_shift(sz, off);
    assign msk     = size_mask(sz);
    assign rd_word = 32'(hline.data >> sh) & msk;
    assign wr_data = (hline.data & ~(LINE_W'(msk) << sh))
                   | (LINE_W'(dat_q & msk) << sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        unique case (state_q)
            S_IDLE:
                if (accept) state_d = S_LOOKUP;
            S_LOOKUP:
                if (is_inv) begin
                    way_d   = hit1;
                    state_d = (hit && hline.dirty) ? S_WRITEBACK : S_RESPOND;
                end else if (hit) begin
                    state_d = S_RESPOND;
                end else begin
                    way_d   = vway;
                    state_d = (vline.valid && vline.dirty) ? S_WRITEBACK : S_REFILL;
                end
            S_WRITEBACK:
                if (mem_done) state_d = is_inv ? S_RESPOND : S_REFILL;
            S_REFILL:
                if (mem_done) state_d = S_LOOKUP;
            S_RESPOND:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        done_d     = 1'b0;
        result_d   = result_q;
        line_we    = 1'b0;
        line_way   = way_q;
        line_wdata = wline;
        lru_we     = 1'b0;
        lru_val    = lru_q[idx];
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {tag, idx};
        mem_wdata  = wline.data;
        unique case (state_q)
            S_IDLE:
                if (accept) begin
                    cmd_d  = cmd_e'(comm);
                    addr_d = addr[18:0];
                    dat_d  = dat;
                end
            S_WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {wline.tag, idx};
            end
            S_REFILL: begin
                mem_req = 1'b1;
                if (mem_done) begin
                    line_we    = 1'b1;
                    line_wdata = '{valid: 1'b1, dirty: 1'b0, tag: tag, data: mem_rdata};
                    lru_we     = 1'b1;
                    lru_val    = ~way_q;
                end
            end
            S_RESPOND: begin
                done_d   = 1'b1;
                line_way = hit1;
                if (is_inv) begin
                    line_we          = hit;
                    line_wdata       = hline;
                    line_wdata.valid = 1'b0;
                    line_wdata.dirty = 1'b0;
                end else begin
                    lru_we  = 1'b1;
                    lru_val = ~hit1;
                    if (is_wr) begin
                        line_we          = 1'b1;
                        line_wdata       = hline;
                        line_wdata.dirty = 1'b1;
                        line_wdata.data  = wr_data;
                    end else begin
                        result_d = rd_word;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= C_NOP;
            addr_q   <= '0;
            dat_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            way_q    <= 1'b0;
            lru_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    lines_q[s][w].valid <= 1'b0;
                    lines_q[s][w].dirty <= 1'b0;
                end
            end
        end else begin
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            result_q <= result_d;
            done_q   <= done_d;
            way_q    <= way_d;
            if (line_we) lines_q[idx][line_way] <= line_wdata;
            if (lru_we)  lru_q[idx] <= lru_val;
        end
    end

    cache_mem_model u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (mem_req),
        .we        (mem_we),
        .line_addr (mem_addr),
        .wdata     (mem_wdata),
        .rdata     (mem_rdata),
        .done      (mem_done)
    );

endmodule

// File: tb/tb_cache_cpu.sv
// Scoreboard bench: flat-memory view plus tag/LRU occupancy model predicts data and latency.
module tb_cache_cpu;

    localparam int HIT  = 2;
    localparam int MEML = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  comm  = '0;
    logic [19:0] addr  = '0;
    logic [31:0] dat   = '0;
    logic        ready, done;
    logic [31:0] result;

    cache_cpu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (valid),
        .comm   (comm),
        .addr   (addr),
        .dat    (dat),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        int          cmd;
    } exp_t;

    exp_t sbq[$];

    // view: what the CPU should observe; backing: what main memory holds.
    bit [7:0]    view    [524288];
    bit [7:0]    backing [524288];
    bit [7:0]    snap    [524288];
    int          mtag    [32][2];
    bit          mval    [32][2];
    bit          mdirty  [32][2];
    bit          mlru    [32];
    logic [31:0] last_res = '0;

    function automatic void copy_line(int tg, int st);
        int base = (tg << 9) | (st << 4);
        for (int i = 0; i < 16; i++) backing[base + i] = view[base + i];
    endfunction

    function automatic exp_t model(int c, logic [19:0] a, logic [31:0] d);
        exp_t e;
        int tg = int'(a[18:9]);
        int st = int'(a[8:4]);
        int hw = -1;
        int w, n, base;
        for (int k = 0; k < 2; k++)
            if (mval[st][k] && mtag[st][k] == tg) hw = k;
        if (c == 4) begin
            e.lat = HIT;
            if (hw >= 0) begin
                if (mdirty[st][hw]) begin
                    copy_line(tg, st);
                    e.lat = HIT + MEML;
                end
                mval[st][hw]   = 1'b0;
                mdirty[st][hw] = 1'b0;
            end
        end else begin
            if (hw >= 0) begin
                e.lat = HIT;
            end else begin
                w = !mval[st][0] ? 0 : !mval[st][1] ? 1 : int'(mlru[st]);
                if (mval[st][w] && mdirty[st][w]) begin
                    copy_line(mtag[st][w], st);
                    e.lat = HIT + 2 * MEML + 1;
                end else begin
                    e.lat = HIT + MEML + 1;
                end
                mval[st][w]   = 1'b1;
                mdirty[st][w] = 1'b0;
                mtag[st][w]   = tg;
                hw = w;
            end
            mlru[st] = (hw == 0);
            n = 1 << ((c & 3) - 1);
            base = int'(a[18:0]) & ~(n - 1);
            if (c >= 5) begin
                for (int i = 0; i < n; i++) view[base + i] = d[8*i +: 8];
                mdirty[st][hw] = 1'b1;
            end else begin
                last_res = '0;
                for (int i = 0; i < n; i++)
                    last_res = last_res | (32'(view[base + i]) << (8 * i));
            end
        end
        e.res = last_res;
        e.cmd = c;
        e.acc = 0;
        return e;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 32; s++) begin
            mlru[s] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mval[s][k]   = 1'b0;
                mdirty[s][k] = 1'b0;
            end
        end
        last_res = '0;
        backing  = snap;
        view     = backing;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic issue(input int c, input logic [19:0] a, input logic [31:0] d);
        exp_t e;
        int w = 0;
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles", ready, w);
            return;
        end
        valid = 1'b1;
        comm  = 3'(c);
        addr  = a;
        dat   = d;
        if (c != 0) begin
            e = model(c, a, d);
            e.acc = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        valid = 1'b0;
        comm  = '0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sbq.size() != 0 || !ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0 || !ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d ready=%b", sbq.size(), ready);
        end
    endtask

    task automatic rand_cmd();
        int r  = $urandom_range(0, 3);
        int tg = (r == 0) ? 256 : (r == 1) ? 262 : (r == 2) ? 300 : $urandom_range(0, 1023);
        int s  = $urandom_range(0, 2);
        int st = (s == 2) ? 3 : s;
        logic [19:0] a;
        a = {1'($urandom_range(0, 1)), 10'(tg), 5'(st), 4'($urandom_range(0, 15))};
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue($urandom_range(0, 7), a, $urandom);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   lat;
        if (rst_n && done) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding, result=%h", result);
            end else begin
                e   = sbq.pop_front();
                lat = cyc - e.acc;
                if (lat != e.lat || result !== e.res) begin
                    n_bad++;
                    $display("FAIL cmd%0d: got lat=%0d result=%h, want lat=%0d result=%h",
                             e.cmd, lat, result, e.lat, e.res);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3, 20'h20008, 32'h0);
        issue(7, 20'h20008, 32'h801F7FFF);
        issue(3, 20'h20008, 32'h0);
        issue(7, 20'h20C08, 32'h8C1F7FFF);
        issue(3, 20'h20C08, 32'h0);
        issue(3, 20'h20008, 32'h0);
        issue(4, 20'h20008, 32'h0);
        issue(3, 20'h20008, 32'h0);
        issue(7, 20'h20008, 32'h801F7FFF);
        issue(3, 20'h20C08, 32'h0);
        issue(3, 20'h25808, 32'h0);
        issue(3, 20'h20008, 32'h0);
        issue(0, 20'h20008, 32'h0);
        issue(5, 20'h00005, 32'hFFFFFFAB);
        issue(6, 20'h00006, 32'hFFFF1234);
        issue(3, 20'h00004, 32'h0);
        issue(2, 20'h00007, 32'h0);
        issue(1, 20'h00005, 32'h0);
        issue(4, 20'h99999, 32'h0);

        repeat (300) rand_cmd();

        issue(7, 20'h00630, 32'h11111111);
        issue(7, 20'h00A30, 32'h22222222);
        drain();
        snap = backing;
        issue(3, 20'h01230, 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        model_reset();
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(3, 20'h00630, 32'h0);
        issue(3, 20'h00A30, 32'h0);
        issue(3, 20'h01230, 32'h0);

        repeat (150) rand_cmd();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_cpu.md
Name: cache_cpu

Overview:
- CPU-facing cache subsystem used as the memory target of processor-side test traffic.
- Accepts 8/16/32-bit read, write and line-invalidate commands on a 19-bit byte address.
- Serves commands from a 2-way set-associative, write-back, write-allocate cache: 32 sets, 16-byte lines.
- Backed by an internal 512 KiB main-memory model with fixed access latency.

Parameters:
- TAG_W, 10, tag bits addr[18:9]
- IDX_W, 5, set index addr[8:4] (32 sets)
- OFF_W, 4, byte offset addr[3:0] (16-byte line)
- WAYS, 2, associativity (fixed; LRU is one bit per set)
- HIT_LAT, 2, cycles from accept to done on a hit
- MEM_LAT, 8, cycles per full-line memory transfer (read or write-back)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  command request; sampled with comm/addr/dat at accept
- comm  in  3  0 NOP, 1 READ8, 2 READ16, 3 READ32, 4 INVALIDATE_LINE, 5 WRITE8, 6 WRITE16, 7 WRITE32
- addr  in  20  byte address; bits[18:0] used, bit 19 ignored
- dat  in  32  write data, LSB-aligned
- ready  out  1  high when idle and able to accept
- done  out  1  one-cycle pulse when the accepted command completes
- result  out  32  read data of the last completed read; holds otherwise

Behaviour:
- Reset (async, rst_n=0): ready=1, done=0, result=0, all valid/dirty bits 0, LRU bits 0, FSM to IDLE. Memory array is not cleared by reset; it is zero at time 0.
- Accept: rising edge with valid=1, ready=1, comm!=0. The block latches comm/addr/dat and drops ready next cycle.
- valid with comm=0 is ignored. Inputs are don't-care while ready=0.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- LOOKUP compares the tag against both ways of set addr[8:4].
- Hit: done exactly HIT_LAT cycles after accept.
- Miss, victim clean or invalid: REFILL (MEM_LAT cycles), then complete the access, then RESPOND.
- Miss, victim dirty: WRITEBACK (MEM_LAT) first, then REFILL.
- Victim selection: an invalid way if any (way 0 first), else the LRU way.
- Any read/write hit or fill marks the used way MRU.
- Reads:
  - READ8 returns byte at offset, zero-extended.
  - READ16 ignores addr[0]; returns little-endian halfword, zero-extended.
  - READ32 ignores addr[1:0]; returns little-endian word.
  - result updates on the same edge done asserts.
- Writes: WRITE8/16/32 store dat[7:0]/[15:0]/[31:0] with the same alignment rules. Line set dirty; result unchanged.
- INVALIDATE_LINE:
  - Line present and dirty: write back (MEM_LAT), clear valid and dirty, done.
  - Present and clean: clear valid, done after HIT_LAT.
  - Absent: no-op, done after HIT_LAT.
  - LRU is unchanged.
- After RESPOND, ready returns high the cycle after done.
- Back-to-back: a new command may be accepted the cycle ready is high.
- Reset mid-operation aborts the command: no done, and memory is not written by a partial write-back.

Decomposition:
- Package cache_pkg:
  - command enum (C_NOP..C_WRITE32)
  - TAG_W/IDX_W/OFF_W/WAYS constants
  - line struct {valid, dirty, tag, data[127:0]}
  - address field extraction functions
- One sub-module cache_mem_model: 2^19-byte array, line-granular read/write with MEM_LAT-cycle busy and done handshake.

Test Plan:
- Reset then READ32 @0x20008 (miss, memory zero) -> result=0x00000000; done at HIT_LAT+MEM_LAT+1 cycles.
- WRITE32 0x801F7FFF @0x20008; READ32 @0x20008 -> result=0x801F7FFF, hit latency HIT_LAT.
- WRITE32 0x8C1F7FFF @0x20C08 (same set 0, tag 262); READ32 @0x20C08 -> 0x8C1F7FFF. Re-read 0x20008 -> 0x801F7FFF, both ways resident.
- INVALIDATE_LINE @0x20008 (dirty) -> done after MEM_LAT write-back. READ32 @0x20008 misses -> 0x801F7FFF from memory.
- Fill set 0 with tags 256 and 262 (both dirty), touch 262, access tag 300 -> way holding 256 evicted with write-back. READ32 @0x20008 -> 0x801F7FFF.
- WRITE8 0xAB @0x00005, WRITE16 0x1234 @0x00006; READ32 @0x00004 -> 0x1234AB00. READ16 @0x00007 -> 0x00001234. READ8 @0x00005 -> 0x000000AB.
